// File: rtl/la_capture_ctrl.sv
// rtl/la_capture_ctrl.sv - logic-analyser capture sequencer: arm, tick divider, edge trigger, FIFO write
// Optional LA_INPUT_SYNC_EN: 2-flop synchronizer on din ahead of trigger detection and storage.
module la_capture_ctrl #(
  parameter int INPUT_WIDTH = 6,
  parameter int CNT_WIDTH   = 32,
  parameter int CFG_MAX     = 12
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   sample_run,
  input  logic [CNT_WIDTH-1:0]   sample_num,
  input  logic [3:0]             sample_clk_cfg,
  input  logic [1:0]             triger_type,
  input  logic [2:0]             trigger_channel,
  input  logic [INPUT_WIDTH-1:0] din,
  input  logic                   fifo_afull,
  output logic                   wr_en,
  output logic [INPUT_WIDTH-1:0] wr_data,
  output logic                   armed,
  output logic                   busy,
  output logic                   capture_done,
  output logic                   overflow,
  output logic [CNT_WIDTH-1:0]   cap_count
);

  typedef enum logic [1:0] {S_IDLE, S_ARM, S_CAPTURE, S_DONE} state_t;

  localparam logic [3:0] CFG_MAX_C = 4'(CFG_MAX);

  state_t                 state, state_nxt;
  logic                   run_q;
  logic [3:0]             cfg_q;
  logic [1:0]             type_q;
  logic [2:0]             chan_q;
  logic [CNT_WIDTH-1:0]   num_q;
  logic [15:0]            div;
  logic [15:0]            div_max;
  logic                   first_q;
  logic [INPUT_WIDTH-1:0] prev;
  logic [INPUT_WIDTH-1:0] din_s;
  logic                   start, tick, store;
  logic                   trig_imm, edge_hit, sel_prev, sel_cur;
  logic [CNT_WIDTH-1:0]   cnt_next;
  logic [3:0]             cfg_in;

`ifdef LA_INPUT_SYNC_EN
  logic [INPUT_WIDTH-1:0] sync1, sync2;
  always_ff @(posedge clk) begin
    if (rst) begin
      sync1 <= '0;
      sync2 <= '0;
    end else begin
      sync1 <= din;
      sync2 <= sync1;
    end
  end
  assign din_s = sync2;
`else
  assign din_s = din;
`endif

  assign cfg_in   = (sample_clk_cfg > CFG_MAX_C) ? CFG_MAX_C : sample_clk_cfg;
  assign start    = (state == S_IDLE) && sample_run && !run_q;
  assign tick     = (div == 16'd0);
  assign div_max  = 16'((17'd1 << cfg_q) - 17'd1);
  assign trig_imm = (type_q == 2'b00) || ({29'd0, chan_q} >= 32'(INPUT_WIDTH));

  // Channel select by loop so out-of-range indices never address a missing bit.
  always_comb begin
    sel_prev = 1'b0;
    sel_cur  = 1'b0;
    for (int i = 0; i < INPUT_WIDTH; i++) begin
      if (chan_q == 3'(i)) begin
        sel_prev = prev[i];
        sel_cur  = din_s[i];
      end
    end
  end

  always_comb begin
    case (type_q)
      2'b01:   edge_hit = !sel_prev && sel_cur;
      2'b10:   edge_hit = sel_prev && !sel_cur;
      2'b11:   edge_hit = sel_prev ^ sel_cur;
      default: edge_hit = 1'b0;
    endcase
  end

  always_comb begin
    if (state == S_ARM)
      cnt_next = CNT_WIDTH'(1);
    else if (&cap_count)
      cnt_next = cap_count;
    else
      cnt_next = cap_count + CNT_WIDTH'(1);
  end

  always_ff @(posedge clk) begin
    if (rst) state <= S_IDLE;
    else     state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    store     = 1'b0;
    case (state)
      S_IDLE: begin
        if (start)
          state_nxt = (sample_num == '0) ? S_DONE : S_ARM;
      end
      S_ARM: begin
        if (!sample_run) begin
          state_nxt = S_IDLE;
        end else if (tick && (trig_imm || (!first_q && edge_hit))) begin
          store     = 1'b1;
          state_nxt = (num_q == CNT_WIDTH'(1)) ? S_DONE : S_CAPTURE;
        end
      end
      S_CAPTURE: begin
        if (!sample_run) begin
          state_nxt = S_IDLE;
        end else if (tick) begin
          store = 1'b1;
          if (cnt_next == num_q)
            state_nxt = S_DONE;
        end
      end
      S_DONE: begin
        if (!sample_run)
          state_nxt = S_IDLE;
      end
      default: state_nxt = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      run_q     <= 1'b0;
      cfg_q     <= '0;
      type_q    <= '0;
      chan_q    <= '0;
      num_q     <= '0;
      div       <= '0;
      first_q   <= 1'b0;
      prev      <= '0;
      cap_count <= '0;
      overflow  <= 1'b0;
      wr_en     <= 1'b0;
      wr_data   <= '0;
    end else begin
      run_q <= sample_run;
      wr_en <= 1'b0;
      if (start) begin
        cfg_q     <= cfg_in;
        type_q    <= triger_type;
        chan_q    <= trigger_channel;
        num_q     <= sample_num;
        div       <= '0;
        first_q   <= 1'b1;
        cap_count <= '0;
        overflow  <= 1'b0;
      end else if (state == S_ARM || state == S_CAPTURE) begin
        div <= (div == div_max) ? 16'd0 : div + 16'd1;
        if (state == S_ARM && tick) begin
          prev    <= din_s;
          first_q <= 1'b0;
        end
      end
      // A dropped sample still counts so the sample index stays aligned to time.
      if (store) begin
        cap_count <= cnt_next;
        if (fifo_afull) begin
          overflow <= 1'b1;
        end else begin
          wr_en   <= 1'b1;
          wr_data <= din_s;
        end
      end
    end
  end

  assign armed        = (state == S_ARM);
  assign busy         = (state == S_ARM) || (state == S_CAPTURE);
  assign capture_done = (state == S_DONE);

endmodule

// File: tb/tb_la_capture_ctrl.sv
// tb/tb_la_capture_ctrl.sv - self-checking bench for la_capture_ctrl
module tb_la_capture_ctrl;

  logic        clk = 1'b0;
  logic        rst;
  logic        sample_run;
  logic [31:0] sample_num;
  logic [3:0]  sample_clk_cfg;
  logic [1:0]  triger_type;
  logic [2:0]  trigger_channel;
  logic [5:0]  din;
  logic        fifo_afull;
  logic        wr_en;
  logic [5:0]  wr_data;
  logic        armed, busy, capture_done, overflow;
  logic [31:0] cap_count;

  int total = 0;
  int bad   = 0;
  int cyc   = 0;
  int af_lo = 0;
  int af_hi = 0;
  bit sb_on = 1'b1;
  logic [5:0] exp_q[$];
  int         wr_times[$];

  la_capture_ctrl dut (
    .clk(clk), .rst(rst), .sample_run(sample_run), .sample_num(sample_num),
    .sample_clk_cfg(sample_clk_cfg), .triger_type(triger_type),
    .trigger_channel(trigger_channel), .din(din), .fifo_afull(fifo_afull),
    .wr_en(wr_en), .wr_data(wr_data), .armed(armed), .busy(busy),
    .capture_done(capture_done), .overflow(overflow), .cap_count(cap_count)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  // FIFO back-pressure window expressed in sample indices (1-based).
  assign fifo_afull = (af_lo > 0) && busy && (int'(cap_count) + 1 >= af_lo) &&
                      (int'(cap_count) + 1 <= af_hi);

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  always @(negedge clk) begin
    if (!rst && sb_on && wr_en) begin
      wr_times.push_back(cyc);
      if (exp_q.size() == 0) begin
        chk("unexpected_write", 64'(wr_data), 64'hdead);
      end else begin
        chk("wr_data", 64'(wr_data), 64'(exp_q.pop_front()));
      end
    end
  end

  task automatic start_cap(input logic [3:0] cfg, input logic [1:0] typ, input logic [2:0] ch,
                           input logic [31:0] num);
    @(negedge clk);
    sample_run = 1'b0;
    sample_clk_cfg = cfg; triger_type = typ; trigger_channel = ch; sample_num = num;
    @(negedge clk);
    wr_times.delete();
    sample_run = 1'b1;
    @(negedge clk);
    // scrambled config after the start edge must be ignored
    sample_clk_cfg = 4'd5; triger_type = 2'b10; trigger_channel = 3'd1; sample_num = 32'd77;
  endtask

  task automatic wait_done(input int limit);
    int n = 0;
    while (!capture_done && n < limit) begin
      @(negedge clk);
      n++;
    end
    chk("done_reached", 64'(capture_done), 64'd1);
  endtask

  task automatic finish_cap(input string tag, input logic [31:0] cnt, input logic ovf, input int nwr,
                            input int gap);
    bit gap_ok = 1'b1;
    repeat (3) @(negedge clk);
    chk({tag, "_cap_count"}, 64'(cap_count), 64'(cnt));
    chk({tag, "_overflow"}, 64'(overflow), 64'(ovf));
    chk({tag, "_writes"}, 64'(wr_times.size()), 64'(nwr));
    chk({tag, "_sb_empty"}, 64'(exp_q.size()), 64'd0);
    chk({tag, "_busy"}, 64'(busy), 64'd0);
    if (gap > 0) begin
      for (int i = 1; i < wr_times.size(); i++)
        if (wr_times[i] - wr_times[i-1] != gap) gap_ok = 1'b0;
      chk({tag, "_spacing"}, 64'(gap_ok), 64'd1);
    end
    sample_run = 1'b0;
    @(negedge clk);
    chk({tag, "_done_clr"}, 64'(capture_done), 64'd0);
    exp_q.delete();
  endtask

  typedef struct {
    logic [3:0]  cfg;
    logic [1:0]  typ;
    logic [2:0]  ch;
    logic [31:0] num;
    logic [5:0]  dval;
    int          lo, hi;
    int          nwr;
    logic        ovf;
    int          gap;
  } vec_t;

  vec_t vecs[8];

  initial begin
    vecs[0] = '{4'd0,  2'b00, 3'd0, 32'd4, 6'h15, 0, 0, 4, 1'b0, 1};
    vecs[1] = '{4'd1,  2'b00, 3'd0, 32'd5, 6'h2A, 0, 0, 5, 1'b0, 2};
    vecs[2] = '{4'd0,  2'b01, 3'd7, 32'd3, 6'h3F, 0, 0, 3, 1'b0, 1};
    vecs[3] = '{4'd0,  2'b00, 3'd0, 32'd8, 6'h0C, 3, 4, 6, 1'b1, 0};
    vecs[4] = '{4'd3,  2'b11, 3'd6, 32'd2, 6'h01, 0, 0, 2, 1'b0, 8};
    vecs[5] = '{4'd15, 2'b00, 3'd0, 32'd2, 6'h11, 0, 0, 2, 1'b0, 4096};
    vecs[6] = '{4'd2,  2'b00, 3'd0, 32'd1, 6'h07, 0, 0, 1, 1'b0, 0};
    vecs[7] = '{4'd0,  2'b00, 3'd0, 32'd0, 6'h33, 0, 0, 0, 1'b0, 0};

    rst = 1'b1; sample_run = 1'b0; sample_num = '0; sample_clk_cfg = '0;
    triger_type = '0; trigger_channel = '0; din = '0;
    repeat (3) @(posedge clk);
    #1;
    chk("rst_wr_en", 64'(wr_en), 64'd0);
    chk("rst_outs", 64'({armed, busy, capture_done, overflow}), 64'd0);
    chk("rst_cap_count", 64'(cap_count), 64'd0);
    chk("rst_wr_data", 64'(wr_data), 64'd0);
    @(negedge clk);
    rst = 1'b0;

    foreach (vecs[v]) begin
      din = vecs[v].dval;
      af_lo = vecs[v].lo; af_hi = vecs[v].hi;
      for (int k = 1; k <= int'(vecs[v].num); k++)
        if (!(af_lo > 0 && k >= af_lo && k <= af_hi)) exp_q.push_back(vecs[v].dval);
      start_cap(vecs[v].cfg, vecs[v].typ, vecs[v].ch, vecs[v].num);
      wait_done(20000);
      finish_cap($sformatf("vec%0d", v), vecs[v].num, vecs[v].ovf, vecs[v].nwr, vecs[v].gap);
      af_lo = 0; af_hi = 0;
    end

    // Rising edge on channel 3 at cfg=2
    din = 6'h21;
    start_cap(4'd2, 2'b01, 3'd3, 32'd3);
    repeat (9) @(negedge clk);
    chk("rise_armed", 64'(armed), 64'd1);
    chk("rise_no_write", 64'(wr_times.size()), 64'd0);
    repeat (3) exp_q.push_back(6'h29);
    din = 6'h29;
    wait_done(200);
    finish_cap("rise", 32'd3, 1'b0, 3, 4);

    // Falling on channel 0 held high: stays armed until it drops
    din = 6'h3F;
    start_cap(4'd0, 2'b10, 3'd0, 32'd3);
    repeat (50) @(negedge clk);
    chk("fall_armed", 64'(armed), 64'd1);
    chk("fall_no_write", 64'(wr_times.size()), 64'd0);
    chk("fall_not_done", 64'(capture_done), 64'd0);
    repeat (3) exp_q.push_back(6'h3E);
    din = 6'h3E;
    wait_done(200);
    finish_cap("fall", 32'd3, 1'b0, 3, 1);

    // Abort after 10 samples, with sample 2 dropped
    begin
      int n = 0;
      din = 6'h2D;
      af_lo = 2; af_hi = 2;
      repeat (9) exp_q.push_back(6'h2D);
      start_cap(4'd2, 2'b00, 3'd0, 32'd100);
      while (cap_count != 32'd10 && n < 1000) begin
        @(negedge clk);
        n++;
      end
      chk("abort_reach10", 64'(cap_count), 64'd10);
      sample_run = 1'b0;
      @(posedge clk);
      #1;
      chk("abort_idle", 64'({busy, capture_done}), 64'd0);
      repeat (6) @(negedge clk);
      chk("abort_cap_count", 64'(cap_count), 64'd10);
      chk("abort_overflow", 64'(overflow), 64'd1);
      chk("abort_writes", 64'(wr_times.size()), 64'd9);
      chk("abort_sb_empty", 64'(exp_q.size()), 64'd0);
      af_lo = 0; af_hi = 0;
    end

    // Restart with num=0: done one cycle after start, overflow cleared, no writes
    sample_num = 32'd0; sample_clk_cfg = 4'd0; triger_type = 2'b00;
    wr_times.delete();
    @(negedge clk);
    sample_run = 1'b1;
    @(posedge clk);
    #1;
    chk("num0_done", 64'(capture_done), 64'd1);
    chk("num0_ovf_clr", 64'(overflow), 64'd0);
    chk("num0_count", 64'(cap_count), 64'd0);
    repeat (4) @(negedge clk);
    chk("num0_writes", 64'(wr_times.size()), 64'd0);
    sample_run = 1'b0;
    @(negedge clk);

    // Reset mid-capture: no trailing write
    sb_on = 1'b0;
    din = 6'h12;
    start_cap(4'd0, 2'b00, 3'd0, 32'd50);
    repeat (4) @(negedge clk);
    rst = 1'b1; sample_run = 1'b0;
    @(posedge clk);
    #1;
    chk("rstmid_wr_en", 64'(wr_en), 64'd0);
    chk("rstmid_busy", 64'(busy), 64'd0);
    chk("rstmid_count", 64'(cap_count), 64'd0);
    @(negedge clk);
    rst = 1'b0;
    @(posedge clk);
    #1;
    chk("rstmid_wr_en2", 64'(wr_en), 64'd0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
